alu_mult_seq: RTL and testbench
===============================

Name: alu_mult_seq

Overview:
Iterative shift-and-add multiplier that acts as the initiator on the ALU operation interface (op, data1, data2 -> result, zero). It accepts a start request and issues one ALU operation per cycle: add for accumulate, shift-left for multiplicand doubling. It samples the ALU result and returns a 32-bit product with a done pulse. It sits beside the datapath ALU and borrows it for multi-cycle multiply instructions.

Parameters:
WIDTH, 32, operand/product width; must match the ALU data width.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only in IDLE
op_a  input  WIDTH  multiplicand, captured on accepted start
op_b  input  WIDTH  multiplier, captured on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; product valid
product  output  WIDTH  low WIDTH bits of op_a*op_b; held until the next DONE
prod_zero  output  1  product==0, updated with product
alu_op  output  3  ALU opcode driven to the ALU
alu_data1  output  WIDTH  ALU operand 1
alu_data2  output  WIDTH  ALU operand 2
alu_result  input  WIDTH  ALU result, combinational in the same cycle
alu_zero  input  1  ALU zero flag (used for prod_zero on the add path)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, product, prod_zero, alu_op, alu_data1, alu_data2 all 0. Internal registers M, Q, P are cleared.
- Reset mid-operation: the multiply is aborted and no done pulse is produced.
- alu_op/alu_data1/alu_data2 are combinational from the current state and registers. alu_result is captured at the clock edge ending that state.
- IDLE: ALU drive is op 000, data1=0, data2=0.
  - On start: M<=op_a, Q<=op_b, P<=0.
  - If op_a==0 or op_b==0 -> DONE.
  - Else if op_b[0] -> ADD, else -> SHIFT.
- ADD: drive op 010, data1=P, data2=M. P<=alu_result. Next state is SHIFT.
- SHIFT: drive op 111, data1=M, data2=1. M<=alu_result; Q<=Q>>1.
  - If (Q>>1)==0 -> DONE.
  - Else if Q[1] -> ADD, else -> SHIFT.
- DONE: done=1 and busy=1 for exactly one cycle. product<=P and prod_zero<=(P==0), loaded on the edge entering DONE so they are valid while done=1. Next state is IDLE.
- Latency: start edge -> DONE cycle = (ones in op_b up to its MSB set bit) + (index of MSB set bit + 1) + 1. With either operand zero the latency is 1.
- Arithmetic wraps modulo 2^WIDTH. No overflow indication. Bits shifted out of M are discarded.
- start while busy: ignored, with no queueing.
- start held high continuously: a new multiply is accepted on the first IDLE cycle after DONE.

Optional Feature:
Macro SIGNED_MULT_EN.
- Defined:
  - Adds an is_signed input, captured with start.
  - When is_signed=1, M and Q are loaded with the two's-complement magnitudes and neg<=op_a[WIDTH-1]^op_b[WIDTH-1].
  - The exit from SHIFT goes to NEG when neg=1. NEG drives op 110, data1=0, data2=P, sets P<=alu_result, then goes to DONE. This adds 1 cycle.
  - Zero-operand shortcut is unchanged and product stays 0.
- Not defined: no is_signed port and no NEG state; all operands are unsigned.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SHL=3'b111, shared with the ALU and ALU control.
  - The mult_state_t enum {IDLE, ADD, SHIFT, NEG, DONE}.
- No sub-module: the ALU is instantiated externally. The bench instantiates the existing ALU with reset tied low and connects it to the alu_* ports.

Test Plan:
- op_a=3, op_b=5, start 1 cycle -> sequence ADD, SHIFT, SHIFT, ADD, SHIFT; done in cycle 6 after start edge; product=15, prod_zero=0.
- op_a=0x1234, op_b=0 -> done in cycle 1 after start; product=0, prod_zero=1; no ADD/SHIFT ALU ops issued.
- op_a=op_b=0xFFFFFFFF -> 64 ADD/SHIFT cycles; done in cycle 65; product=0x00000001 (wrap).
- start asserted again with op_a=7 during busy -> ignored; original product=15 returned; busy/done timing unchanged.
- reset pulsed in cycle 3 of 3*5 -> next cycle IDLE, busy=0, product=0, no done; a following 2*2 yields product=4.
- SIGNED_MULT_EN, is_signed=1, op_a=-3, op_b=5 -> NEG cycle issues op 110; product=0xFFFFFFF1, done in cycle 7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the iterative multiplier state type.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SHL = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      ADD,
      SHIFT,
      NEG,
      DONE
   } mult_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// Shift-and-add multiplier that borrows the datapath ALU, one operation per cycle.
// Optional signed operands are enabled with the SIGNED_MULT_EN macro.
module alu_mult_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef SIGNED_MULT_EN
   input  logic             is_signed,
`endif
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             prod_zero,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_data1,
   output logic [WIDTH-1:0] alu_data2,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   mult_state_t      state, state_nxt;
   logic [WIDTH-1:0] m_reg, q_reg, p_reg;
   logic [WIDTH-1:0] q_shr;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             p_zero;
   logic             operand_zero;
   logic             neg_now;

`ifdef SIGNED_MULT_EN
   logic neg;
   assign mag_a   = (is_signed && op_a[WIDTH-1]) ? ('0 - op_a) : op_a;
   assign mag_b   = (is_signed && op_b[WIDTH-1]) ? ('0 - op_b) : op_b;
   assign neg_now = neg;
`else
   assign mag_a   = op_a;
   assign mag_b   = op_b;
   assign neg_now = 1'b0;
`endif

   assign q_shr        = q_reg >> 1;
   assign operand_zero = (op_a == '0) || (op_b == '0);

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = 1'b0;
      alu_op    = ALU_AND;
      alu_data1 = '0;
      alu_data2 = '0;
      case (state)
         IDLE: begin
            if (start) begin
               if (operand_zero)
                  state_nxt = DONE;
               else if (op_b[0])
                  state_nxt = ADD;
               else
                  state_nxt = SHIFT;
            end
         end
         ADD: begin
            alu_op    = ALU_ADD;
            alu_data1 = p_reg;
            alu_data2 = m_reg;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            alu_op    = ALU_SHL;
            alu_data1 = m_reg;
            alu_data2 = {{(WIDTH-1){1'b0}}, 1'b1};
            // Q[1] is the next multiplier bit once this shift retires
            if (q_shr == '0)
               state_nxt = neg_now ? NEG : DONE;
            else if (q_reg[1])
               state_nxt = ADD;
            else
               state_nxt = SHIFT;
         end
`ifdef SIGNED_MULT_EN
         NEG: begin
            alu_op    = ALU_SUB;
            alu_data1 = '0;
            alu_data2 = p_reg;
            state_nxt = DONE;
         end
`endif
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // product/prod_zero are loaded on the edge entering DONE; p_zero tracks P==0
   // from the ALU zero flag so no separate comparator on P is needed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         m_reg     <= '0;
         q_reg     <= '0;
         p_reg     <= '0;
         p_zero    <= 1'b0;
         product   <= '0;
         prod_zero <= 1'b0;
`ifdef SIGNED_MULT_EN
         neg       <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  m_reg  <= mag_a;
                  q_reg  <= mag_b;
                  p_reg  <= '0;
                  p_zero <= 1'b1;
`ifdef SIGNED_MULT_EN
                  neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`endif
                  if (operand_zero) begin
                     product   <= '0;
                     prod_zero <= 1'b1;
                  end
               end
            end
            ADD: begin
               p_reg  <= alu_result;
               p_zero <= alu_zero;
            end
            SHIFT: begin
               m_reg <= alu_result;
               q_reg <= q_shr;
               if ((q_shr == '0) && !neg_now) begin
                  product   <= p_reg;
                  prod_zero <= p_zero;
               end
            end
`ifdef SIGNED_MULT_EN
            NEG: begin
               p_reg     <= alu_result;
               p_zero    <= alu_zero;
               product   <= alu_result;
               prod_zero <= alu_zero;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq with a behavioural ALU attached to its alu_* ports.
module tb_alu_mult_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  op_a, op_b;
   logic          busy, done, prod_zero;
   logic [W-1:0]  product;
   logic [2:0]    alu_op;
   logic [W-1:0]  alu_data1, alu_data2, alu_result;
   logic          alu_zero;

   int checks = 0;
   int errors = 0;
   logic [2:0] op_trace[$];

   always #5 clk = ~clk;

   alu_mult_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
`ifdef SIGNED_MULT_EN
      .is_signed(is_signed),
`endif
      .op_a(op_a),
      .op_b(op_b),
      .busy(busy),
      .done(done),
      .product(product),
      .prod_zero(prod_zero),
      .alu_op(alu_op),
      .alu_data1(alu_data1),
      .alu_data2(alu_data2),
      .alu_result(alu_result),
      .alu_zero(alu_zero)
   );

   // Behavioural stand-in for the datapath ALU.
   always_comb begin
      case (alu_op)
         ALU_AND: alu_result = alu_data1 & alu_data2;
         ALU_OR:  alu_result = alu_data1 | alu_data2;
         ALU_ADD: alu_result = alu_data1 + alu_data2;
         ALU_SUB: alu_result = alu_data1 - alu_data2;
         ALU_SHL: alu_result = alu_data1 << alu_data2;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] full;
      full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return full[W-1:0];
   endfunction

   function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
      return (sgn && v[W-1]) ? (~v + 32'd1) : v;
   endfunction

   // One add per set multiplier bit, one shift per bit up to the top set bit, plus DONE.
   function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      int ones, top;
      logic [W-1:0] mb;
      if (a == 0 || b == 0) return 1;
      mb = mag(b, sgn);
      ones = 0;
      top = 0;
      for (int i = 0; i < W; i++)
         if (mb[i]) begin
            ones++;
            top = i;
         end
      return ones + top + 2 + ((sgn && (a[W-1] ^ b[W-1])) ? 1 : 0);
   endfunction

   // Starts a multiply and waits for done; poke_cyc>0 re-asserts start with op_a=7 in that busy cycle.
   task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input logic [W-1:0] exp_p, input int exp_lat, input int poke_cyc,
                          input string nm);
      int lat;
      op_trace.delete();
      @(negedge clk);
      op_a = a; op_b = b; is_signed = sgn; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 200) begin
         op_trace.push_back(alu_op);
         chk({nm, " busy"}, {63'd0, busy}, 64'd1);
         if (lat == poke_cyc) begin
            start = 1'b1; op_a = 32'd7; op_b = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, " product"}, {32'd0, product}, {32'd0, exp_p});
      chk({nm, " prod_zero"}, {63'd0, prod_zero}, {63'd0, exp_p == 0});
      chk({nm, " busy_in_done"}, {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      chk({nm, " done_one_cycle"}, {62'd0, done, busy}, 64'd0);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_p;
      int           exp_lat;
      string        nm;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int done_cycles[$];
      logic [W-1:0] ra, rb;
      logic         rs;

      vecs[0] = '{32'd3,          32'd5,          32'd15,         6,  "3x5"};
      vecs[1] = '{32'h1234,       32'd0,          32'd0,          1,  "b_zero"};
      vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          65, "all_ones"};
      vecs[3] = '{32'd1,          32'd1,          32'd1,          3,  "1x1"};
      vecs[4] = '{32'h8000_0000,  32'd2,          32'd0,          4,  "wrap_zero"};
      vecs[5] = '{32'd0,          32'd7,          32'd0,          1,  "a_zero"};

      reset = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset product", {32'd0, product}, 64'd0);
      chk("reset prod_zero", {63'd0, prod_zero}, 64'd0);
      chk("reset alu_drive", {29'd0, alu_op, alu_data1}, 64'd0);
      chk("reset alu_data2", {32'd0, alu_data2}, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         do_mult(vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_p, vecs[i].exp_lat, 0, vecs[i].nm);
         if (i == 0) begin
            chk("3x5 op_count", 64'(op_trace.size()), 64'd5);
            if (op_trace.size() == 5) begin
               chk("3x5 op1", {61'd0, op_trace[0]}, {61'd0, ALU_ADD});
               chk("3x5 op2", {61'd0, op_trace[1]}, {61'd0, ALU_SHL});
               chk("3x5 op3", {61'd0, op_trace[2]}, {61'd0, ALU_SHL});
               chk("3x5 op4", {61'd0, op_trace[3]}, {61'd0, ALU_ADD});
               chk("3x5 op5", {61'd0, op_trace[4]}, {61'd0, ALU_SHL});
            end
         end
         if (i == 1) chk("b_zero no_alu_ops", 64'(op_trace.size()), 64'd0);
      end

      // Start while busy is ignored.
      do_mult(32'd3, 32'd5, 1'b0, 32'd15, 6, 2, "busy_restart");

      // Reset in cycle 3 aborts without a done pulse.
      @(negedge clk);
      op_a = 32'd3; op_b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort busy", {63'd0, busy}, 64'd0);
      chk("abort product", {32'd0, product}, 64'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
         end
         chk("abort no_done", 64'(seen), 64'd0);
      end
      do_mult(32'd2, 32'd2, 1'b0, 32'd4, 4, 0, "after_abort");

      // Start held high: back-to-back multiplies, second accepted in the IDLE after DONE.
      @(negedge clk);
      op_a = 32'd1; op_b = 32'd1; start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (done) done_cycles.push_back(c);
      end
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("held_start done_count", 64'(done_cycles.size()) > 64'd1 ? 64'd2 : 64'(done_cycles.size()), 64'd2);
      if (done_cycles.size() >= 2) begin
         chk("held_start first", 64'(done_cycles[0]), 64'd3);
         chk("held_start second", 64'(done_cycles[1]), 64'd7);
      end

`ifdef SIGNED_MULT_EN
      do_mult(-32'sd3, 32'd5, 1'b1, 32'hFFFF_FFF1, 7, 0, "signed_m3x5");
      chk("signed neg_op", {61'd0, op_trace[op_trace.size()-1]}, {61'd0, ALU_SUB});
      do_mult(-32'sd4, -32'sd6, 1'b1, 32'd24, model_lat(-32'sd4, -32'sd6, 1'b1), 0, "signed_m4xm6");
`endif

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom & ((i % 3 == 0) ? 32'hFFFF_FFFF : 32'h0000_03FF);
         if (i % 7 == 3) ra = '0;
         rs = 1'b0;
`ifdef SIGNED_MULT_EN
         rs = $urandom_range(0, 1) == 1;
`endif
         do_mult(ra, rb, rs, model_prod(ra, rb), model_lat(ra, rb, rs), 0, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
